// File: rtl/sequencer_pkg.sv
// Shared definitions for the program sequencer: op encodings and op width.
package sequencer_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_INC     = 3'd0,
        OP_BR_REL  = 3'd1,
        OP_BR_COND = 3'd2,
        OP_BR_ABS  = 3'd3,
        OP_CALL    = 3'd4,
        OP_RET     = 3'd5,
        OP_HALT    = 3'd6,
        OP_RSVD    = 3'd7
    } op_e;

endpackage

// File: rtl/return_stack.sv
// LIFO return-address stack. Push is ignored when full, pop when empty.
// dout always shows the top entry; it is meaningless while empty.
module return_stack #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               CLK,
    input  logic                               rst,
    input  logic                               push,
    input  logic                               pop,
    input  logic [PC_W-1:0]                    din,
    output logic [PC_W-1:0]                    dout,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               full,
    output logic                               empty
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    // Address width; the array is rounded up to a power of two so any
    // AW-bit index is in range. Entries past STACK_DEPTH are never written.
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DW-1:0] MAX_DEPTH = DW'(STACK_DEPTH);

    logic [PC_W-1:0] mem_q [2**AW];
    logic [DW-1:0]   depth_q, depth_d;
    logic            do_push, do_pop;

    assign full    = (depth_q == MAX_DEPTH);
    assign empty   = (depth_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign depth   = depth_q;
    assign dout    = mem_q[AW'(depth_q - DW'(1))];

    // Next occupancy from the qualified push/pop requests.
    always_comb begin
        depth_d = depth_q;
        if (do_push && !do_pop) begin
            depth_d = depth_q + DW'(1);
        end else if (do_pop && !do_push) begin
            depth_d = depth_q - DW'(1);
        end
    end

    // Occupancy register, cleared asynchronously.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Entry storage; no reset needed since entries above depth are unreachable.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[AW'(depth_q)] <= din;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program counter sequencer with relative/absolute/conditional branches,
// call/return through a return stack, halt, and a sticky stack error flag.
module program_sequencer
    import sequencer_pkg::*;
#(
    parameter int          PC_W        = 8,
    parameter int          OFFS_W      = 8,
    parameter int          STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                               CLK,
    input  logic                               rst,
    input  logic                               en,
    input  logic [OP_W-1:0]                    op,
    input  logic                               flag,
    input  logic [PC_W-1:0]                    target,
    input  logic [OFFS_W-1:0]                  offset,
    output logic [PC_W-1:0]                    PC,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               halted,
    output logic                               stack_err
);

    // Elaboration-time parameter sanity checks.
    if (OFFS_W > PC_W) begin : g_chk_offs
        $error("program_sequencer: OFFS_W must not exceed PC_W");
    end
    if (STACK_DEPTH < 1) begin : g_chk_depth
        $error("program_sequencer: STACK_DEPTH must be at least 1");
    end

    logic [PC_W-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            err_q, err_d;
    logic [PC_W-1:0] pc_inc, pc_rel, offs_ext, stk_dout;
    logic            stk_push, stk_pop, stk_full, stk_empty, advance;

    assign advance  = en && !halted_q;
    assign offs_ext = PC_W'($signed(offset));
    assign pc_inc   = pc_q + PC_W'(1);
    assign pc_rel   = pc_q + offs_ext;

    return_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .CLK   (CLK),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .depth (depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Next PC, halt/error flags and stack requests; push and pop are
    // mutually exclusive because they come from different op codes.
    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (advance) begin
            case (op_e'(op))
                OP_BR_REL:  pc_d = pc_rel;
                OP_BR_COND: pc_d = flag ? pc_rel : pc_inc;
                OP_BR_ABS:  pc_d = target;
                OP_CALL: begin
                    if (stk_full) begin
                        pc_d  = pc_inc;
                        err_d = 1'b1;
                    end else begin
                        pc_d     = target;
                        stk_push = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stk_empty) begin
                        pc_d  = pc_inc;
                        err_d = 1'b1;
                    end else begin
                        pc_d    = stk_dout;
                        stk_pop = 1'b1;
                    end
                end
                OP_HALT:    halted_d = 1'b1;
                default:    pc_d = pc_inc;
            endcase
        end
    end

    // PC, halted and sticky error registers with asynchronous reset.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign PC        = pc_q;
    assign halted    = halted_q;
    assign stack_err = err_q;

endmodule
